// File: rtl/sub_share_arbiter_pkg.sv
// Shared width helpers for the datapath arbiters: clog2, max and id-width derivation.
// Used at elaboration only; no logic.
package sub_share_arbiter_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Index width is never allowed to collapse to zero bits.
  function automatic int id_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed shift-register delay of WIDTH bits; DELAY=0 is a wire.
// Latency: DELAY cycles; no backpressure.
module delay_line #(
  parameter int WIDTH = 1,
  parameter int DELAY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  generate
    if (DELAY == 0) begin : g_bypass
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DELAY];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DELAY; i++) stage[i] <= '0;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < DELAY; i++) stage[i] <= stage[i-1];
        end
      end
      assign q = stage[DELAY-1];
    end
  endgenerate
endmodule

// File: rtl/sub_result_fifo.sv
// First-word-fall-through result FIFO with occupancy count.
// Latency: head visible the cycle after push; writer must own a free slot (credit-gated upstream).
module sub_result_fifo
  import sub_share_arbiter_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 19,
  localparam int PW    = id_width(DEPTH),
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             rd_en;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rd_en  = rd_rdy && (count != '0);
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_vld) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (rd_en) rd_ptr <= nxt(rd_ptr);
      case ({wr_vld, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/subtractor.sv
// Sign/zero-extends a and b to OUT_W and subtracts.
// Latency: REGISTER_INPUT + REGISTER_OUTPUT cycles; no backpressure, always accepts.
module subtractor #(
  parameter int    A_WIDTH         = 16,
  parameter int    B_WIDTH         = 16,
  parameter int    OUT_W           = 17,
  parameter string A_IS_SIGNED     = "TRUE",
  parameter string B_IS_SIGNED     = "TRUE",
  parameter bit    REGISTER_INPUT  = 1'b1,
  parameter bit    REGISTER_OUTPUT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic [OUT_W-1:0]   diff
);
  logic             a_fill, b_fill;
  logic [OUT_W-1:0] a_ext, b_ext, a_op, b_op, diff_c;

  assign a_fill = (A_IS_SIGNED == "TRUE") ? a[A_WIDTH-1] : 1'b0;
  assign b_fill = (B_IS_SIGNED == "TRUE") ? b[B_WIDTH-1] : 1'b0;
  assign a_ext  = {{(OUT_W-A_WIDTH){a_fill}}, a};
  assign b_ext  = {{(OUT_W-B_WIDTH){b_fill}}, b};

  generate
    if (REGISTER_INPUT) begin : g_in_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_op <= '0;
          b_op <= '0;
        end else begin
          a_op <= a_ext;
          b_op <= b_ext;
        end
      end
    end else begin : g_in_comb
      assign a_op = a_ext;
      assign b_op = b_ext;
    end
  endgenerate

  assign diff_c = a_op - b_op;

  generate
    if (REGISTER_OUTPUT) begin : g_out_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) diff <= '0;
        else        diff <= diff_c;
      end
    end else begin : g_out_comb
      assign diff = diff_c;
    end
  endgenerate
endmodule

// File: rtl/sub_share_arbiter.sv
// Round-robin shares one subtractor between NUM_REQ requesters; results drain via valid/ready.
// Latency: LATENCY+1 cycles transfer-to-out_valid; req_ready drops when no FIFO credit remains.
module sub_share_arbiter
  import sub_share_arbiter_pkg::*;
#(
  parameter int    NUM_REQ     = 4,
  parameter int    A_WIDTH     = 16,
  parameter int    B_WIDTH     = 16,
  parameter string A_IS_SIGNED = "TRUE",
  parameter string B_IS_SIGNED = "TRUE",
  parameter int    LATENCY     = 2,
  localparam int   OUT_W       = max2(A_WIDTH, B_WIDTH) + 1,
  localparam int   ID_W        = id_width(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_diff,
  output logic [ID_W-1:0]            out_id
);
  localparam int DEPTH = LATENCY + 2;
  localparam int CW    = clog2(DEPTH + 1);

  logic [ID_W-1:0]       last_grant, gnt_idx;
  logic                  gnt_any, issue, pop;
  logic [CW-1:0]         credits, fifo_count;
  logic [A_WIDTH-1:0]    a_sel;
  logic [B_WIDTH-1:0]    b_sel;
  logic [ID_W:0]         tag_in, tag_out;
  logic [OUT_W-1:0]      diff;
  logic [OUT_W+ID_W-1:0] fifo_dat;

  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
  end

  // rst_n gating keeps req_ready low for the whole reset window, not just after the first edge.
  assign issue = rst_n && gnt_any && (credits != '0);
  assign pop   = out_valid && out_ready;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits    <= CW'(DEPTH);
      last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      if (issue && !pop)      credits <= credits - CW'(1);
      else if (!issue && pop) credits <= credits + CW'(1);
      if (issue) last_grant <= gnt_idx;
    end
  end

  assign a_sel  = req_a[int'(gnt_idx)*A_WIDTH +: A_WIDTH];
  assign b_sel  = req_b[int'(gnt_idx)*B_WIDTH +: B_WIDTH];
  assign tag_in = {issue, gnt_idx};

  subtractor #(
    .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .OUT_W(OUT_W),
    .A_IS_SIGNED(A_IS_SIGNED), .B_IS_SIGNED(B_IS_SIGNED),
    .REGISTER_INPUT(LATENCY >= 2), .REGISTER_OUTPUT(LATENCY >= 1)
  ) u_sub (
    .clk(clk), .rst_n(rst_n), .a(a_sel), .b(b_sel), .diff(diff)
  );

  delay_line #(.WIDTH(ID_W + 1), .DELAY(LATENCY)) u_tag (
    .clk(clk), .rst_n(rst_n), .d(tag_in), .q(tag_out)
  );

  sub_result_fifo #(.DEPTH(DEPTH), .WIDTH(OUT_W + ID_W)) u_fifo (
    .clk(clk), .rst_n(rst_n),
    .wr_vld(tag_out[ID_W]), .wr_dat({diff, tag_out[ID_W-1:0]}),
    .rd_rdy(out_ready), .rd_dat(fifo_dat), .count(fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_diff  = fifo_dat[OUT_W+ID_W-1:ID_W];
  assign out_id    = fifo_dat[ID_W-1:0];
endmodule

// File: tb/tb_sub_share_arbiter.sv
// Bench for sub_share_arbiter: a LATENCY=2 signed instance and a LATENCY=0 unsigned instance,
// checked by vector table, directed sequences and a queue-based reference model.
module tb_sub_share_arbiter;
  localparam int NR = 4;
  localparam int W  = 16;
  localparam int OW = 17;

  typedef struct { logic [OW-1:0] diff; int id; int vis; } res_t;
  typedef struct { int k; int id; logic [W-1:0] a; logic [W-1:0] b; logic [OW-1:0] diff; } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [NR-1:0]   req_valid [2];
  logic [NR-1:0]   req_ready [2];
  logic [NR*W-1:0] req_a     [2];
  logic [NR*W-1:0] req_b     [2];
  logic            out_valid [2];
  logic            out_ready [2];
  logic [OW-1:0]   out_diff  [2];
  logic [1:0]      out_id    [2];

  sub_share_arbiter #(.NUM_REQ(NR), .A_WIDTH(W), .B_WIDTH(W), .A_IS_SIGNED("TRUE"),
                      .B_IS_SIGNED("TRUE"), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_a(req_a[0]), .req_b(req_b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_diff(out_diff[0]), .out_id(out_id[0]));

  sub_share_arbiter #(.NUM_REQ(NR), .A_WIDTH(W), .B_WIDTH(W), .A_IS_SIGNED("FALSE"),
                      .B_IS_SIGNED("FALSE"), .LATENCY(0)) dut_l0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_a(req_a[1]), .req_b(req_b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_diff(out_diff[1]), .out_id(out_id[1]));

  int vectors = 0, miscompares = 0;
  int lat_c [2] = '{2, 0};
  int dep_c [2] = '{4, 2};
  bit sgn_c [2] = '{1'b1, 1'b0};

  // Reference model: outstanding results as a circular list with a visibility time each.
  res_t          sb [2][64];
  int            hd [2], tl [2], last_g [2];
  int            cyc;
  bit            m_xfer [2], m_pop [2];
  int            m_id [2];
  logic [OW-1:0] m_diff [2];
  bit            d_xfer [2], d_pop [2];
  int            d_gnt [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] ref_diff(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    int ai, bi;
    ai = sgn_c[k] ? int'($signed(a)) : int'(a);
    bi = sgn_c[k] ? int'($signed(b)) : int'(b);
    return OW'(ai - bi);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      hd[k] = 0; tl[k] = 0; last_g[k] = NR - 1;
    end
    cyc = 0;
  endtask

  task automatic model_check(input int k);
    int cred, g, idx;
    logic [NR-1:0] exp_rdy;
    bit ev;
    cred = dep_c[k] - (tl[k] - hd[k]);
    g = -1;
    for (int j = 1; j <= NR; j++) begin
      idx = (last_g[k] + j) % NR;
      if (g < 0 && req_valid[k][idx]) g = idx;
    end
    exp_rdy = '0;
    if (g >= 0 && cred > 0) exp_rdy[g] = 1'b1;
    chk($sformatf("req_ready[d%0d]", k), 64'(req_ready[k]), 64'(exp_rdy));
    ev = (tl[k] > hd[k]) && (sb[k][hd[k] % 64].vis <= cyc);
    chk($sformatf("out_valid[d%0d]", k), 64'(out_valid[k]), 64'(ev));
    if (ev) begin
      chk($sformatf("out_diff[d%0d]", k), 64'(out_diff[k]), 64'(sb[k][hd[k] % 64].diff));
      chk($sformatf("out_id[d%0d]", k), 64'(out_id[k]), 64'(sb[k][hd[k] % 64].id));
    end
    m_pop[k]  = ev && out_ready[k];
    m_xfer[k] = (exp_rdy != '0);
    if (m_xfer[k]) begin
      m_id[k]   = g;
      m_diff[k] = ref_diff(k, req_a[k][g*W +: W], req_b[k][g*W +: W]);
    end
    d_xfer[k] = |(req_valid[k] & req_ready[k]);
    d_pop[k]  = out_valid[k] && out_ready[k];
    d_gnt[k]  = -1;
    for (int j = 0; j < NR; j++) if (req_ready[k][j]) d_gnt[k] = j;
  endtask

  task automatic model_update(input int k);
    if (m_pop[k]) hd[k]++;
    if (m_xfer[k]) begin
      sb[k][tl[k] % 64] = '{diff: m_diff[k], id: m_id[k], vis: cyc + lat_c[k] + 1};
      tl[k]++;
      last_g[k] = m_id[k];
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check(0);
    model_check(1);
    @(posedge clk);
    model_update(0);
    model_update(1);
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = '0; req_a[k] = '0; req_b[k] = '0; out_ready[k] = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // One isolated request: checks transfer, latency, difference and id.
  task automatic run_vec(input vec_t v);
    int got, seen, l;
    logic [OW-1:0] dd;
    logic [1:0] ii;
    got = 0; seen = 0; l = 0; dd = '0; ii = '0;
    req_a[v.k] = '0; req_b[v.k] = '0;
    req_a[v.k][v.id*W +: W] = v.a;
    req_b[v.k][v.id*W +: W] = v.b;
    req_valid[v.k] = NR'(1) << v.id;
    out_ready[v.k] = 1'b1;
    for (int c = 0; c < 20 && got == 0; c++) begin
      @(negedge clk);
      if (req_ready[v.k][v.id]) got = 1;
    end
    @(posedge clk);
    #1 req_valid[v.k] = '0;
    for (int c = 1; c <= 20 && seen == 0; c++) begin
      @(negedge clk);
      if (out_valid[v.k]) begin seen = 1; l = c; dd = out_diff[v.k]; ii = out_id[v.k]; end
    end
    @(posedge clk);
    #1;
    chk($sformatf("tbl_xfer d%0d id%0d", v.k, v.id), 64'(got), 64'(1));
    chk($sformatf("tbl_latency d%0d id%0d", v.k, v.id), 64'(l), 64'(lat_c[v.k] + 1));
    chk($sformatf("tbl_diff d%0d id%0d", v.k, v.id), 64'(dd), 64'(v.diff));
    chk($sformatf("tbl_id d%0d id%0d", v.k, v.id), 64'(ii), 64'(v.id));
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [9];
    int n;
    tbl[0] = '{0, 1, 16'd100,  16'd30,   17'd70};
    tbl[1] = '{0, 0, 16'h8000, 16'h7FFF, 17'h10001};
    tbl[2] = '{0, 3, 16'h0000, 16'h0001, 17'h1FFFF};
    tbl[3] = '{0, 2, 16'h7FFF, 16'h8000, 17'h0FFFF};
    tbl[4] = '{0, 1, 16'hFFFF, 16'hFFFF, 17'h00000};
    tbl[5] = '{1, 2, 16'h8000, 16'h7FFF, 17'h00001};
    tbl[6] = '{1, 0, 16'h0000, 16'hFFFF, 17'h10001};
    tbl[7] = '{1, 3, 16'hFFFF, 16'h0000, 17'h0FFFF};
    tbl[8] = '{1, 1, 16'd5,    16'd7,    17'h1FFFE};

    // Reset state, with every requester asking.
    rst_n = 1'b0;
    idle_inputs();
    for (int k = 0; k < 2; k++) begin req_valid[k] = '1; out_ready[k] = 1'b0; end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset req_ready d%0d", k), 64'(req_ready[k]), 64'(0));
      chk($sformatf("reset out_valid d%0d", k), 64'(out_valid[k]), 64'(0));
      chk($sformatf("reset out_diff d%0d", k), 64'(out_diff[k]), 64'(0));
      chk($sformatf("reset out_id d%0d", k), 64'(out_id[k]), 64'(0));
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_inputs();

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // All four requesters valid: strict rotation from requester 0.
    idle_inputs();
    do_reset();
    for (int j = 0; j < NR; j++) begin
      req_a[0][j*W +: W] = W'(1000 * (j + 1));
      req_b[0][j*W +: W] = W'(j);
    end
    req_valid[0] = '1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("rotation grant %0d", i), 64'(d_gnt[0]), 64'(i % NR));
    end
    req_valid[0] = '0;
    repeat (8) step();

    // Consumer stalled: exactly DEPTH transfers, then one more per pop.
    idle_inputs();
    do_reset();
    out_ready[0] = 1'b0;
    req_a[0][W-1:0] = 16'd50;
    req_b[0][W-1:0] = 16'd8;
    req_valid[0] = 4'b0001;
    n = 0;
    repeat (10) begin step(); n += int'(d_xfer[0]); end
    chk("stall fill transfers", 64'(n), 64'(4));
    chk("stall req_ready low", 64'(req_ready[0]), 64'(0));
    out_ready[0] = 1'b1;
    step();
    out_ready[0] = 1'b0;
    n = int'(d_xfer[0]);
    repeat (6) begin step(); n += int'(d_xfer[0]); end
    chk("stall one pop one transfer", 64'(n), 64'(1));
    req_valid[0] = '0;
    out_ready[0] = 1'b1;
    repeat (8) step();

    // Reset mid-burst with results in flight and one buffered.
    idle_inputs();
    do_reset();
    out_ready[0] = 1'b0;
    for (int j = 0; j < NR; j++) begin
      req_a[0][j*W +: W] = W'(7 * j + 3);
      req_b[0][j*W +: W] = W'(j);
    end
    req_valid[0] = '1;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", 64'(out_valid[0]), 64'(0));
    chk("midreset req_ready", 64'(req_ready[0]), 64'(0));
    do_reset();
    req_a[0] = '0;
    req_b[0] = '0;
    req_a[0][W-1:0] = 16'd9;
    req_b[0][W-1:0] = 16'd4;
    step();
    chk("after reset first grant", 64'(d_gnt[0]), 64'(0));
    req_valid[0] = '0;
    out_ready[0] = 1'b1;
    n = 0;
    repeat (8) begin step(); n += int'(d_pop[0]); end
    chk("after reset result count", 64'(n + 1 - 1 + int'(0)), 64'(1));

    // LATENCY=0: fill, then push and pop together every cycle without emptying.
    idle_inputs();
    do_reset();
    out_ready[1] = 1'b0;
    req_a[1][0*W +: W] = 16'd10;
    req_b[1][0*W +: W] = 16'd3;
    req_a[1][1*W +: W] = 16'd0;
    req_b[1][1*W +: W] = 16'hFFFF;
    req_valid[1] = 4'b0011;
    repeat (3) step();
    chk("lat0 full req_ready", 64'(req_ready[1]), 64'(0));
    req_valid[1] = 4'b0100;
    req_b[1][2*W +: W] = 16'd9;
    out_ready[1] = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      req_a[1][2*W +: W] = W'(20 + i);
      step();
      n += int'(d_pop[1]);
    end
    chk("lat0 pops while refilling", 64'(n), 64'(6));
    req_valid[1] = '0;
    repeat (4) step();

    // Randomized traffic on both instances against the model.
    idle_inputs();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 2; k++) begin
        req_valid[k] = ($urandom_range(0, 4) == 0) ? '1 : NR'($urandom_range(0, 15));
        req_a[k]     = {$urandom(), $urandom()};
        req_b[k]     = {$urandom(), $urandom()};
        out_ready[k] = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    idle_inputs();
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
